// File: rtl/cpup_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpup_mem_pkg : shared state encoding, control-word and bus-select constants
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package cpup_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LATCH = 3'd3,
    ST_READ  = 3'd4,
    ST_WRITE = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam logic [3:0] MC_NONE = 4'b0000;
  localparam logic [3:0] MC_ADDR = 4'b0001;
  localparam logic [3:0] MC_WE   = 4'b0010;
  localparam logic [3:0] MC_RD   = 4'b0100;
  localparam logic [3:0] MC_INST = 4'b1000;

  localparam logic [1:0] BS_NONE  = 2'b00;
  localparam logic [1:0] BS_PC    = 2'b01;
  localparam logic [1:0] BS_DADDR = 2'b10;
  localparam logic [1:0] BS_WDATA = 2'b11;

  localparam int WAIT_W = 4;

  typedef struct packed {
    logic [3:0] mem_ctrl;
    logic [1:0] bus_src;
    logic       fetch_done;
    logic       data_done;
    logic       data_load;
    logic       busy;
  } seq_out_t;

  // Output word for a given state; bus_src is only ever driven outside READ,
  // so the memory controller owns the bus alone while it reads.
  function automatic seq_out_t decode_outputs(state_t st, owner_t own);
    seq_out_t o;
    o          = '0;
    o.mem_ctrl = MC_NONE;
    o.bus_src  = BS_NONE;
    o.busy     = (st != ST_IDLE);
    case (st)
      ST_ADDR: begin
        o.mem_ctrl = MC_ADDR;
        o.bus_src  = (own == OWN_DATA) ? BS_DADDR : BS_PC;
      end
      ST_LATCH: o.mem_ctrl = MC_INST;
      ST_READ: begin
        o.mem_ctrl  = MC_RD;
        o.data_load = 1'b1;
      end
      ST_WRITE: begin
        o.mem_ctrl = MC_WE;
        o.bus_src  = BS_WDATA;
      end
      ST_DONE: begin
        o.fetch_done = (own == OWN_FETCH);
        o.data_done  = (own == OWN_DATA);
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_sequencer_if.sv
// ---------------------------------------------------------------------------
// mem_sequencer_if : requester handshake and memory-controller control bundle
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_sequencer_if;

  logic       fetch_req;
  logic       fetch_done;
  logic       data_req;
  logic       data_we;
  logic       data_done;
  logic       data_load;
  logic [3:0] mem_ctrl;
  logic [1:0] bus_src;
  logic       busy;

  modport master (
    output fetch_req, data_req, data_we,
    input  fetch_done, data_done, data_load, mem_ctrl, bus_src, busy
  );

  modport slave (
    input  fetch_req, data_req, data_we,
    output fetch_done, data_done, data_load, mem_ctrl, bus_src, busy
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter : two-way fetch/data grant, fixed data priority or round-robin
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import cpup_mem_pkg::*;
#(
  parameter int DATA_PRIORITY = 1
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   arb_en,
  input  logic   fetch_req,
  input  logic   data_req,
  output logic   grant_valid,
  output owner_t grant_owner
);

  owner_t last_owner;

  always_comb begin
    grant_valid = fetch_req | data_req;
    grant_owner = data_req ? OWN_DATA : OWN_FETCH;
    if (fetch_req && data_req) begin
      if (DATA_PRIORITY != 0) begin
        grant_owner = OWN_DATA;
      end else begin
        grant_owner = (last_owner == OWN_DATA) ? OWN_FETCH : OWN_DATA;
      end
    end
  end

  // Pointer remembers the most recent winner, tie or not.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_owner <= OWN_FETCH;
    end else if (arb_en && grant_valid) begin
      last_owner <= grant_owner;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_sequencer.sv
// ---------------------------------------------------------------------------
// mem_sequencer : DRAM control-word sequencer and fetch/data port arbiter
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_sequencer
  import cpup_mem_pkg::*;
#(
  parameter int WAIT_CYCLES   = 1,
  parameter int DATA_PRIORITY = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  mem_sequencer_if.slave bus
);

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_range_check
      $error("mem_sequencer: WAIT_CYCLES must be within 0..15");
    end
  endgenerate

  localparam int                WAIT_M1   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_M1);

  state_t            state;
  state_t            next_state;
  state_t            access_state;
  owner_t            owner;
  owner_t            next_owner;
  owner_t            grant_owner;
  logic              is_store;
  logic              next_is_store;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] next_wait_cnt;
  logic              arb_en;
  logic              grant_valid;
  seq_out_t          out_q;
  seq_out_t          next_out;

  assign arb_en       = (state == ST_IDLE);
  assign access_state = (owner == OWN_DATA) ? ST_READ : ST_LATCH;

  mem_arbiter #(
    .DATA_PRIORITY (DATA_PRIORITY)
  ) u_arbiter (
    .clock       (clock),
    .reset_n     (reset_n),
    .arb_en      (arb_en),
    .fetch_req   (bus.fetch_req),
    .data_req    (bus.data_req),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      owner    <= OWN_FETCH;
      is_store <= 1'b0;
      wait_cnt <= '0;
      out_q    <= '0;
    end else begin
      state    <= next_state;
      owner    <= next_owner;
      is_store <= next_is_store;
      wait_cnt <= next_wait_cnt;
      out_q    <= next_out;
    end
  end

  always_comb begin
    next_state    = state;
    next_owner    = owner;
    next_is_store = is_store;
    next_wait_cnt = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          next_state    = ST_ADDR;
          next_owner    = grant_owner;
          next_is_store = (grant_owner == OWN_DATA) && bus.data_we;
        end
      end
      ST_ADDR: begin
        if ((owner == OWN_DATA) && is_store) begin
          next_state = ST_WRITE;
        end else if (WAIT_CYCLES == 0) begin
          next_state = access_state;
        end else begin
          next_state    = ST_WAIT;
          next_wait_cnt = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          next_state = access_state;
        end else begin
          next_wait_cnt = wait_cnt - 1'b1;
        end
      end
      ST_LATCH, ST_READ, ST_WRITE: next_state = ST_DONE;
      ST_DONE:                     next_state = ST_IDLE;
      default:                     next_state = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    next_out = decode_outputs(next_state, next_owner);
  end

  assign bus.mem_ctrl   = out_q.mem_ctrl;
  assign bus.bus_src    = out_q.bus_src;
  assign bus.fetch_done = out_q.fetch_done;
  assign bus.data_done  = out_q.data_done;
  assign bus.data_load  = out_q.data_load;
  assign bus.busy       = out_q.busy;

endmodule

`default_nettype wire

// File: tb/tb_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_sequencer : scoreboard bench, u0 WAIT=1 round-robin, u1 WAIT=2 data-priority
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_sequencer;

  typedef struct packed {
    logic       busy;
    logic [3:0] mc;
    logic [1:0] bs;
    logic       dl;
    logic       fd;
    logic       dd;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn [2];
  logic freq [2];
  logic dreq [2];
  logic dwe  [2];
  obs_t obs  [2];

  int   tests = 0;
  int   fails = 0;
  bit   sb_en = 1'b1;
  obs_t exp0[$];
  obs_t exp1[$];

  mem_sequencer_if bus0 ();
  mem_sequencer_if bus1 ();

  assign bus0.fetch_req = freq[0];
  assign bus0.data_req  = dreq[0];
  assign bus0.data_we   = dwe[0];
  assign bus1.fetch_req = freq[1];
  assign bus1.data_req  = dreq[1];
  assign bus1.data_we   = dwe[1];

  assign obs[0] = {bus0.busy, bus0.mem_ctrl, bus0.bus_src, bus0.data_load, bus0.fetch_done, bus0.data_done};
  assign obs[1] = {bus1.busy, bus1.mem_ctrl, bus1.bus_src, bus1.data_load, bus1.fetch_done, bus1.data_done};

  mem_sequencer #(.WAIT_CYCLES(1), .DATA_PRIORITY(0)) u0 (
    .clock   (clk),
    .reset_n (rstn[0]),
    .bus     (bus0.slave)
  );

  mem_sequencer #(.WAIT_CYCLES(2), .DATA_PRIORITY(1)) u1 (
    .clock   (clk),
    .reset_n (rstn[1]),
    .bus     (bus1.slave)
  );

  function automatic obs_t mk(logic [3:0] mc, logic [1:0] bs, logic dl, logic fd, logic dd);
    obs_t o;
    o.busy = 1'b1; o.mc = mc; o.bs = bs; o.dl = dl; o.fd = fd; o.dd = dd;
    return o;
  endfunction

  function automatic int wc(int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic push(int i, obs_t e);
    if (i == 0) exp0.push_back(e);
    else        exp1.push_back(e);
  endtask

  // kind: 0 fetch, 1 load, 2 store
  task automatic push_txn(int i, int kind);
    if (kind == 0) begin
      push(i, mk(4'b0001, 2'b01, 1'b0, 1'b0, 1'b0));
      repeat (wc(i)) push(i, mk(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0));
      push(i, mk(4'b1000, 2'b00, 1'b0, 1'b0, 1'b0));
      push(i, mk(4'b0000, 2'b00, 1'b0, 1'b1, 1'b0));
    end else if (kind == 1) begin
      push(i, mk(4'b0001, 2'b10, 1'b0, 1'b0, 1'b0));
      repeat (wc(i)) push(i, mk(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0));
      push(i, mk(4'b0100, 2'b00, 1'b1, 1'b0, 1'b0));
      push(i, mk(4'b0000, 2'b00, 1'b0, 1'b0, 1'b1));
    end else begin
      push(i, mk(4'b0001, 2'b10, 1'b0, 1'b0, 1'b0));
      push(i, mk(4'b0010, 2'b11, 1'b0, 1'b0, 1'b0));
      push(i, mk(4'b0000, 2'b00, 1'b0, 1'b0, 1'b1));
    end
  endtask

  task automatic sb_compare(int i, obs_t got);
    obs_t e;
    tests++;
    if ((i == 0 && exp0.size() == 0) || (i == 1 && exp1.size() == 0)) begin
      fails++;
      $display("FAIL sb_u%0d: unexpected output busy/mc/bs/dl/fd/dd=%b, required no activity", i, got);
      return;
    end
    if (i == 0) e = exp0.pop_front();
    else        e = exp1.pop_front();
    if (got !== e) begin
      fails++;
      $display("FAIL sb_u%0d @%0t: busy/mc/bs/dl/fd/dd got %b required %b", i, $time, got, e);
    end
  endtask

  task automatic check_invariants(int i, obs_t o);
    tests++;
    if (!$onehot0(o.mc) || (o.mc[2] && o.bs != 2'b00)) begin
      fails++;
      $display("FAIL invariant_u%0d @%0t: mem_ctrl=%b bus_src=%b, required one-hot/zero and no driver during read", i, $time, o.mc, o.bs);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check_invariants(i, obs[i]);
      if (sb_en && obs[i] != '0) sb_compare(i, obs[i]);
    end
  end

  // Waits for the owner's done pulse, then drops that request one cycle later.
  task automatic wait_done(int i, bit data, string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (data ? obs[i].dd : obs[i].fd) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_u%0d: %s done pulse seen=0 within 40 cycles, required 1", tag, i, data ? "data" : "fetch");
    end
    @(posedge clk); #1;
    if (data) dreq[i] = 1'b0;
    else      freq[i] = 1'b0;
  endtask

  task automatic txn(int i, int kind, bit flip_we);
    push_txn(i, kind);
    if (kind == 0) begin
      freq[i] = 1'b1;
    end else begin
      dwe[i]  = (kind == 2);
      dreq[i] = 1'b1;
    end
    if (flip_we) begin
      @(posedge clk); @(posedge clk); #1;
      dwe[i] = ~dwe[i];
    end
    wait_done(i, kind != 0, "txn");
    dwe[i] = 1'b0;
  endtask

  task automatic pair(int i, bit data_first);
    push_txn(i, data_first ? 1 : 0);
    push_txn(i, data_first ? 0 : 1);
    dwe[i]  = 1'b0;
    freq[i] = 1'b1;
    dreq[i] = 1'b1;
    wait_done(i, data_first, "pair_first");
    wait_done(i, !data_first, "pair_second");
  endtask

  task automatic rand_drive(int i);
    repeat (25) begin
      bit f;
      bit d;
      int bound;
      int gap;
      gap   = int'($urandom_range(0, 3));
      f     = ($urandom_range(0, 1) == 1);
      d     = ($urandom_range(0, 1) == 1);
      if (!f && !d) f = 1'b1;
      dwe[i]  = ($urandom_range(0, 1) == 1);
      freq[i] = f;
      dreq[i] = d;
      bound   = 60;
      while ((f || d) && bound > 0) begin
        @(negedge clk);
        bound--;
        if (f && obs[i].fd) begin
          @(posedge clk); #1; freq[i] = 1'b0; f = 1'b0;
        end else if (d && obs[i].dd) begin
          @(posedge clk); #1; dreq[i] = 1'b0; d = 1'b0;
        end
      end
      if (f || d) begin
        tests++;
        fails++;
        $display("FAIL rand_u%0d: outstanding request not completed within 60 cycles, required completion", i);
        freq[i] = 1'b0; dreq[i] = 1'b0; f = 1'b0; d = 1'b0;
      end
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rstn[i] = 1'b1; freq[i] = 1'b0; dreq[i] = 1'b0; dwe[i] = 1'b0;
    end
    #2;
    rstn[0] = 1'b0; rstn[1] = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (obs[i] !== '0) begin
        fails++;
        $display("FAIL reset_u%0d: outputs %b, required all zero", i, obs[i]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // u0: WAIT_CYCLES=1, round-robin ties
    txn(0, 0, 1'b0);
    pair(0, 1'b1);
    pair(0, 1'b1);
    txn(0, 2, 1'b0);
    pair(0, 1'b0);
    txn(0, 1, 1'b0);

    // u1: WAIT_CYCLES=2, data priority
    txn(1, 1, 1'b1);
    txn(1, 2, 1'b0);
    txn(1, 2, 1'b1);
    pair(1, 1'b1);
    pair(1, 1'b1);
    txn(1, 2, 1'b0);
    pair(1, 1'b1);

    // u1: reset during WAIT, request held, fetch restarts from ADDR
    @(posedge clk); #1;
    push(1, mk(4'b0001, 2'b01, 1'b0, 1'b0, 1'b0));
    push(1, mk(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0));
    freq[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #7;
    rstn[1] = 1'b0;
    #1;
    tests++;
    if (obs[1] !== '0) begin
      fails++;
      $display("FAIL reset_abort_u1: outputs %b right after reset, required all zero", obs[1]);
    end
    repeat (2) @(posedge clk);
    #1;
    rstn[1] = 1'b1;
    push_txn(1, 0);
    wait_done(1, 1'b0, "reset_restart");

    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (exp0.size() != 0) begin
      fails++;
      $display("FAIL drain_u0: %0d expected outputs never seen, required 0", exp0.size());
    end
    tests++;
    if (exp1.size() != 0) begin
      fails++;
      $display("FAIL drain_u1: %0d expected outputs never seen, required 0", exp1.size());
    end

    sb_en = 1'b0;
    fork
      rand_drive(0);
      rand_drive(1);
    join
    repeat (10) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
